// File: rtl/irq_controller_if.sv
// Signal bundle between the CPU control unit (master) and irq_controller (slave).
interface irq_controller_if #(
    parameter int N = 4
);
    logic [N-1:0] irq;
    logic         mask_we;
    logic [N-1:0] mask_wd;
    logic         int_en;
    logic         int_ack;
    logic         reti;
    logic         int_req;
    logic [9:0]   vector;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;
    logic [N-1:0] mask;

    modport master (
        output irq, mask_we, mask_wd, int_en, int_ack, reti,
        input  int_req, vector, pending, in_service, mask
    );

    modport slave (
        input  irq, mask_we, mask_wd, int_en, int_ack, reti,
        output int_req, vector, pending, in_service, mask
    );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller with req/ack handshake to the CPU.
// Define IRQ_NESTING_EN to let higher-priority lines preempt an in-service level.
module irq_controller #(
    parameter int         N          = 4,
    parameter logic [9:0] VEC_BASE   = 10'h3C0,
    parameter int         VEC_STRIDE = 4
) (
    input logic             clk,
    input logic             reset,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, ISR} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] irq_prev_q, irq_prev_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] in_service_q, in_service_d;
    logic [N-1:0] req_sel_q, req_sel_d;
    logic [9:0]   vector_q, vector_d;

    logic [N-1:0] rise, isr_low, allow, elig, sel;
    logic         ack_take;

    function automatic logic [9:0] vec_of(input logic [N-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) idx = i;
        end
        return 10'((int'(VEC_BASE) + idx * VEC_STRIDE) % 1024);
    endfunction

    // NOTE: every always_comb output gets its default first so no latch is inferred;
    // state only changes in always_ff with non-blocking assignments.
    always_comb begin
        rise    = bus.irq & ~irq_prev_q;
        isr_low = in_service_q & (-in_service_q);
`ifdef IRQ_NESTING_EN
        allow   = (in_service_q == '0) ? '1 : (isr_low - N'(1));
`else
        allow   = (in_service_q == '0) ? '1 : '0;
`endif
        elig     = pending_q & mask_q & allow;
        sel      = elig & (-elig);
        ack_take = (state_q == REQ) && bus.int_ack;

        irq_prev_d = bus.irq;
        mask_d     = bus.mask_we ? bus.mask_wd : mask_q;

        // A fresh edge on the acknowledged line wins over the ack clear.
        pending_d = pending_q;
        if (ack_take) pending_d = pending_d & ~req_sel_q;
        pending_d = pending_d | rise;

        // reti retires the old level before the acknowledged one is added.
        in_service_d = in_service_q;
        if (bus.reti) in_service_d = in_service_d & ~isr_low;
        if (ack_take) in_service_d = in_service_d | req_sel_q;

        state_d   = state_q;
        req_sel_d = req_sel_q;
        vector_d  = vector_q;
        unique case (state_q)
            IDLE: begin
                if (bus.int_en && elig != '0) begin
                    state_d   = REQ;
                    req_sel_d = sel;
                    vector_d  = vec_of(sel);
                end
            end
            REQ: begin
                if (ack_take)         state_d = ISR;
                else if (!bus.int_en) state_d = IDLE;
            end
            ISR: begin
                if (in_service_d == '0) begin
                    state_d = IDLE;
                end else if (bus.int_en && elig != '0) begin
                    state_d   = REQ;
                    req_sel_d = sel;
                    vector_d  = vec_of(sel);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            req_sel_q    <= '0;
            vector_q     <= '0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            req_sel_q    <= req_sel_d;
            vector_q     <= vector_d;
        end
    end

    assign bus.int_req    = (state_q == REQ);
    assign bus.vector     = vector_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller against a line-level reference model.
module tb_irq_controller;
    localparam int N          = 4;
    localparam int VEC_BASE   = 'h3C0;
    localparam int VEC_STRIDE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    irq_controller_if #(.N(N)) bus ();

    irq_controller #(
        .N(N), .VEC_BASE(10'(VEC_BASE)), .VEC_STRIDE(VEC_STRIDE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    // Reference model: which lines are pending/enabled/in service, and whether the
    // CPU is currently being asked to take a line.
    typedef enum {PH_IDLE, PH_ASKING, PH_SERVING} phase_e;
    phase_e     m_phase = PH_IDLE;
    bit [N-1:0] m_pend  = '0;
    bit [N-1:0] m_mask  = '0;
    bit [N-1:0] m_srv   = '0;
    bit [N-1:0] m_prev  = '0;
    int         m_line  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input bit [N-1:0] irq_v, input bit mwe, input bit [N-1:0] mwd,
                              input bit en, input bit ack, input bit rt);
        int         top_srv;
        int         pick;
        bit         took;
        bit [N-1:0] srv_n;
        top_srv = lowest(m_srv);
        pick    = -1;
        for (int i = N - 1; i >= 0; i--) begin
            bit ok;
            ok = m_pend[i] && m_mask[i];
`ifdef IRQ_NESTING_EN
            if (top_srv >= 0 && i >= top_srv) ok = 1'b0;
`else
            if (top_srv >= 0) ok = 1'b0;
`endif
            if (ok) pick = i;
        end
        took  = (m_phase == PH_ASKING) && ack;
        srv_n = m_srv;
        if (rt && top_srv >= 0) srv_n[top_srv] = 1'b0;
        if (took) begin
            srv_n[m_line]  = 1'b1;
            m_pend[m_line] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (irq_v[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
        case (m_phase)
            PH_IDLE: begin
                if (en && pick >= 0) begin
                    m_phase = PH_ASKING;
                    m_line  = pick;
                    exp_q.push_back((VEC_BASE + pick * VEC_STRIDE) % 1024);
                end
            end
            PH_ASKING: begin
                if (took)     m_phase = PH_SERVING;
                else if (!en) m_phase = PH_IDLE;
            end
            default: begin
                if (srv_n == '0) begin
                    m_phase = PH_IDLE;
                end else if (en && pick >= 0) begin
                    m_phase = PH_ASKING;
                    m_line  = pick;
                    exp_q.push_back((VEC_BASE + pick * VEC_STRIDE) % 1024);
                end
            end
        endcase
        m_srv  = srv_n;
        m_prev = irq_v;
        if (mwe) m_mask = mwd;
    endtask

    task automatic drive(input logic [N-1:0] irq_v, input logic mwe, input logic [N-1:0] mwd,
                         input logic en, input logic ack, input logic rt);
        @(negedge clk);
        check("pending", bus.pending, m_pend);
        check("in_service", bus.in_service, m_srv);
        check("mask", bus.mask, m_mask);
        check("int_req", bus.int_req, m_phase == PH_ASKING);
        bus.irq     = irq_v;
        bus.mask_we = mwe;
        bus.mask_wd = mwd;
        bus.int_en  = en;
        bus.int_ack = ack;
        bus.reti    = rt;
        model_step(irq_v, mwe, mwd, en, ack, rt);
    endtask

    task automatic do_reset(input logic [N-1:0] irq_hold);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_int_req", bus.int_req, 0);
        check("rst_vector", bus.vector, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_in_service", bus.in_service, 0);
        check("rst_mask", bus.mask, 0);
        bus.irq     = irq_hold;
        bus.mask_we = 1'b0;
        bus.mask_wd = '0;
        bus.int_en  = 1'b0;
        bus.int_ack = 1'b0;
        bus.reti    = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        m_phase = PH_IDLE;
        m_pend  = '0;
        m_mask  = '0;
        m_srv   = '0;
        m_prev  = '0;
        m_line  = 0;
        exp_q.delete();
        model_step(irq_hold, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_auto(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive('0, 1'b0, '0, 1'b1, m_phase == PH_ASKING, m_phase != PH_ASKING && m_srv != '0);
        end
    endtask

    // Monitor: every new request must match the next expected vector and hold it.
    initial begin
        bit       prev_req;
        bit [9:0] cur_vec;
        prev_req = 1'b0;
        cur_vec  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (bus.int_req && !prev_req) begin
                    check("sb_has_entry", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur_vec = 10'(exp_q.pop_front());
                        check("vector", bus.vector, cur_vec);
                    end
                end else if (bus.int_req) begin
                    check("vector_hold", bus.vector, cur_vec);
                end
                prev_req = bus.int_req;
            end
        end
    end

    initial begin
        bit [N-1:0] irq_v;
        bus.irq     = '0;
        bus.mask_we = 1'b0;
        bus.mask_wd = '0;
        bus.int_en  = 1'b0;
        bus.int_ack = 1'b0;
        bus.reti    = 1'b0;
        do_reset('0);

        // Single request, ack, return.
        drive('0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("tp1_vector", bus.vector, 10'h3C8);
        check("tp1_req", bus.int_req, 1);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("tp1_in_service", bus.in_service, 4'b0100);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("tp1_after_reti", bus.in_service, 0);

        // Two simultaneous lines: lowest index first.
        drive(4'b1010, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("tp2_first_vector", bus.vector, 10'h3C4);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive('0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("tp2_second_vector", bus.vector, 10'h3CC);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Masked line stays pending until enabled.
        drive('0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("tp3_masked_pending", bus.pending, 4'b0001);
        check("tp3_masked_no_req", bus.int_req, 0);
        drive(4'b0001, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("tp3_vector", bus.vector, 10'h3C0);
        run_auto(4);

        // Withdraw on int_en drop, request again on re-enable.
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("tp4_withdrawn", bus.int_req, 0);
        check("tp4_still_pending", bus.pending, 4'b0100);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("tp4_vector", bus.vector, 10'h3C8);
        run_auto(4);

        // Higher-priority line arriving while line 2 is in service.
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        run_auto(10);

        // Asynchronous reset while a request is outstanding.
        drive(4'b0110, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b0110, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        do_reset('0);

        irq_v = '0;
        for (int c = 0; c < 1500; c++) begin
            bit         mwe, en, ack, rt;
            bit [N-1:0] mwd;
            if (c == 700 || c == 1200) begin
                irq_v = N'($urandom);
                do_reset(irq_v);
            end
            irq_v ^= N'($urandom & $urandom & $urandom);
            mwe = (m_mask == '0) || ($urandom_range(0, 15) == 0);
            mwd = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            en  = ($urandom_range(0, 9) != 0);
            ack = (m_phase == PH_ASKING) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            rt  = (m_srv != '0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            drive(irq_v, mwe, mwd, en, ack, rt);
        end
        run_auto(12);
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised, maskable interrupt controller for the 16-bit single-cycle CPU.
- Sits upstream of the PC-select mux: captures external request edges, selects the highest-priority eligible request (lowest index, isolated lowest set bit), and presents a 10-bit vector address to the fetch path.
- Uses a req/ack handshake with the control unit and tracks in-service levels until return-from-interrupt.

Parameters:
- N, 4: number of interrupt lines (1..8).
- VEC_BASE, 10'h3C0: vector address of line 0.
- VEC_STRIDE, 4: address distance between consecutive line vectors.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces all state to reset values.
- irq  input  N  external requests, rising-edge sensitive, already synchronous to clk.
- mask_we  input  1  load mask register from mask_wd.
- mask_wd  input  N  new mask value (1 = line enabled).
- int_en  input  1  global interrupt enable from the CPU status flag.
- int_ack  input  1  CPU accepts current request at an instruction boundary (PC <= vector).
- reti  input  1  CPU executes return-from-interrupt.
- int_req  output  1  request to CPU.
- vector  output  10  jump address, stable while int_req = 1.
- pending  output  N  latched, not yet acknowledged requests.
- in_service  output  N  lines currently being serviced.
- mask  output  N  current mask register.

Behaviour:
- Reset values: int_req 0, vector 0, pending 0, in_service 0, mask 0 (all lines masked), irq_prev 0, state IDLE, req_sel 0.
- Edge capture: pending[i] is set at the rising clk edge where irq[i] = 1 and irq_prev[i] = 0. irq_prev <= irq every cycle. If irq is high at reset release, the bit is captured on the first edge.
- Masking: mask_we loads mask_wd at the edge. Masked lines stay pending but are not eligible.
- Eligibility: elig = pending & mask & allow.
  - allow is all ones when in_service = 0.
  - Otherwise allow is per the Optional Feature.
- Selection: sel = elig & -elig (lowest index wins). idx = position of sel. Vector = (VEC_BASE + idx*VEC_STRIDE) mod 1024.
- States:
  - IDLE: int_req 0. If int_en and elig != 0, go to REQ and latch req_sel <= sel and vector.
  - REQ: int_req 1, and vector/req_sel are held constant even if a higher-priority line arrives. On int_ack, at the same edge: pending &= ~req_sel, in_service |= req_sel, go to ISR. If int_en = 0 and no int_ack, withdraw to IDLE (pending untouched). int_ack and int_en = 0 in the same cycle: ack wins.
  - ISR: int_req 0. When in_service becomes 0, go to IDLE. With nesting, go ISR -> REQ when int_en and elig != 0.
- Latency: irq edge sampled at edge k; pending visible after k; int_req high after edge k+1. Ack at edge m; int_req low after m.
- reti: in any state with in_service != 0, clears the lowest set bit of in_service. reti with in_service = 0 is ignored.
- Simultaneous events on the same bit:
  - A new irq edge on the bit being acknowledged: set wins, so pending stays 1.
  - reti and int_ack in the same cycle: reti clears the old level first, then the ack bit is ORed in.
- int_ack outside REQ is ignored.
- Reset mid-operation (any state) returns to IDLE with all registers at reset values. Requests outstanding at reset are lost.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- Defined: allow = mask of indices strictly below the lowest set bit of in_service. A higher-priority line may preempt, so in_service may hold several bits. reti pops the highest-priority level.
- Undefined: allow = 0 whenever in_service != 0. No new int_req until reti empties in_service, and in_service holds at most one bit.

Test Plan (N=4, VEC_BASE=10'h3C0, VEC_STRIDE=4):
1. reset, mask_wd=4'hF with mask_we, int_en=1, pulse irq[2] -> pending=4'b0100 after 1 edge; int_req=1, vector=10'h3C8 after next edge. int_ack -> pending=0, in_service=4'b0100, int_req=0. reti -> in_service=0, state IDLE.
2. irq[3] and irq[1] rise in the same cycle -> vector=10'h3C4. After ack+reti for line 1, the second request gives vector=10'h3CC.
3. mask=4'b1110, pulse irq[0] -> no int_req, pending[0]=1. Write mask=4'hF -> int_req=1, vector=10'h3C0 two edges later.
4. In REQ for line 2, drop int_en -> int_req=0 next edge, pending[2] still 1. Raise int_en -> int_req returns with vector=10'h3C8.
5. In ISR for line 2, pulse irq[0]:
   - With IRQ_NESTING_EN: int_req=1, vector=10'h3C0; after ack, in_service=4'b0101. First reti gives 4'b0100, second gives 4'b0000.
   - Without IRQ_NESTING_EN: no int_req until reti, then vector=10'h3C0.
6. Assert reset while in REQ with pending=4'b0110 -> all outputs 0 immediately (asynchronous), state IDLE, mask=0.
